// File: rtl/serial_add_ctrl.sv
// rtl/serial_add_ctrl.sv - bit-serial adder sequencer built around one mux-based full adder
//
// full_adder      : single-bit adder cell, sum and carry built from 2:1 muxes
//   a, b, ci      : operand bits and carry in
//   s, co         : sum bit and carry out
//
// serial_add_ctrl : adds two WIDTH-bit operands one bit per clock, LSB first
//   clk           : system clock, rising edge
//   rst           : synchronous active-high reset
//   start         : request; accepted when the sequencer is not running
//   a, b, cin     : operands and carry-in, captured when start is accepted
//   busy          : high while bits are being added
//   done          : one-cycle pulse, sum/cout valid from this cycle
//   sum, cout     : result registers, hold until the next completion or reset

module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    logic p;

    assign p  = a ^ b;
    // Propagate selects between inverting and passing the carry for the sum,
    // and between the incoming carry and the generate term for the carry out.
    assign s  = ci ? ~p : p;
    assign co = p ? ci : a;
endmodule

module serial_add_ctrl #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state;
    logic [WIDTH-1:0] opa;
    logic [WIDTH-1:0] opb;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_next;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic             fa_s;
    logic             fa_co;

    full_adder u_fa (
        .a  (opa[0]),
        .b  (opb[0]),
        .ci (carry),
        .s  (fa_s),
        .co (fa_co)
    );

    // Each new sum bit enters at the MSB; after WIDTH shifts bit 0 holds the LSB.
    generate
        if (WIDTH == 1) begin : g_acc1
            assign acc_next = fa_s;
        end else begin : g_accn
            assign acc_next = {fa_s, acc[WIDTH-1:1]};
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            cnt   <= '0;
            carry <= 1'b0;
            opa   <= '0;
            opb   <= '0;
            acc   <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                RUN: begin
                    opa   <= opa >> 1;
                    opb   <= opb >> 1;
                    carry <= fa_co;
                    acc   <= acc_next;
                    cnt   <= cnt + CW'(1);
                    if (cnt == CW'(WIDTH - 1)) begin
                        sum   <= acc_next;
                        cout  <= fa_co;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                        cnt   <= '0;
                        state <= DONE;
                    end
                end
                default: begin
                    // The DONE cycle also accepts a request so back-to-back
                    // operations run at one per WIDTH+1 cycles.
                    if (start) begin
                        opa   <= a;
                        opb   <= b;
                        carry <= cin;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= RUN;
                    end else begin
                        state <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb/tb_serial_add_ctrl.sv - self-checking bench for serial_add_ctrl (WIDTH=8 and WIDTH=1)

module tb_serial_add_ctrl;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [7:0] a;
    logic [7:0] b;
    logic       cin;
    logic       busy;
    logic       done;
    logic [7:0] sum;
    logic       cout;

    logic       start1;
    logic [0:0] a1;
    logic [0:0] b1;
    logic       cin1;
    logic       busy1;
    logic       done1;
    logic [0:0] sum1;
    logic       cout1;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    serial_add_ctrl #(.WIDTH(8)) u_dut8 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .cin   (cin),
        .busy  (busy),
        .done  (done),
        .sum   (sum),
        .cout  (cout)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut1 (
        .clk   (clk),
        .rst   (rst),
        .start (start1),
        .a     (a1),
        .b     (b1),
        .cin   (cin1),
        .busy  (busy1),
        .done  (done1),
        .sum   (sum1),
        .cout  (cout1)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
    } vec_t;

    vec_t vecs[8];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Called #1 after an edge; returns how many further edges until done is seen (bounded).
    task automatic wait_done(output int edges);
        edges = 0;
        while (done !== 1'b1 && edges < 40) begin
            @(posedge clk);
            #1;
            edges++;
        end
    endtask

    task automatic run_op(input string name, input logic [7:0] va, input logic [7:0] vb,
                          input logic vc, input logic [7:0] es, input logic ec);
        int n;
        @(negedge clk);
        start = 1'b1;
        a     = va;
        b     = vb;
        cin   = vc;
        @(posedge clk);
        #1;
        start = 1'b0;
        a     = ~va;
        b     = ~vb;
        cin   = ~vc;
        check({name, " busy_after_e0"}, {busy, done}, 2'b10);
        wait_done(n);
        check({name, " latency"}, n, 8);
        check({name, " done_no_busy"}, {busy, done}, 2'b01);
        check({name, " sum_cout"}, {cout, sum}, {ec, es});
        @(posedge clk);
        #1;
        check({name, " done_pulse_end"}, {busy, done}, 2'b00);
    endtask

    initial begin
        int n;
        logic [8:0] exp9;

        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h96, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1};
        vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; cin = 1'b0;
        start1 = 1'b0; a1 = '0; b1 = '0; cin1 = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        check("reset8", {busy, done, cout, sum}, 11'h000);
        check("reset1", {busy1, done1, cout1, sum1}, 4'h0);

        // busy held for exactly 8 cycles on the first vector
        @(negedge clk);
        start = 1'b1; a = 8'h5A; b = 8'h3C; cin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        n = 0;
        for (int i = 0; i < 12; i++) begin
            if (busy) n++;
            @(posedge clk);
            #1;
        end
        check("busy_cycles", n, 8);
        check("first_sum", {cout, sum}, 9'h096);

        for (int i = 0; i < 8; i++)
            run_op($sformatf("vec%0d", i), vecs[i].a, vecs[i].b, vecs[i].cin,
                   vecs[i].exp_sum, vecs[i].exp_cout);

        // start held high; operands change mid-op; second op taken from DONE cycle
        @(negedge clk);
        start = 1'b1; a = 8'h12; b = 8'h34; cin = 1'b0;
        @(posedge clk);
        #1;
        a = 8'h01; b = 8'h02; cin = 1'b1;
        wait_done(n);
        check("held_first_latency", n, 8);
        check("held_first_sum", {cout, sum}, 9'h046);
        @(posedge clk);
        #1;
        check("held_second_started", {busy, done}, 2'b10);
        wait_done(n);
        check("held_second_latency", n + 1, 9);
        check("held_second_sum", {cout, sum}, 9'h004);
        start = 1'b0;
        @(posedge clk);
        #1;
        check("held_then_idle", {busy, done}, 2'b00);

        // reset asserted at the 4th RUN edge discards the partial result
        @(negedge clk);
        start = 1'b1; a = 8'hF0; b = 8'h0F; cin = 1'b0;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrun_reset", {busy, done, cout, sum}, 11'h000);
        repeat (10) @(posedge clk);
        #1;
        check("midrun_reset_idle", {busy, done, cout, sum}, 11'h000);
        run_op("after_reset", 8'h33, 8'h44, 1'b1, 8'h78, 1'b0);

        // random sweep, WIDTH=8
        for (int i = 0; i < 300; i++) begin
            logic [7:0] ra;
            logic [7:0] rb;
            logic       rc;
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            exp9 = {1'b0, ra} + {1'b0, rb} + {8'h00, rc};
            run_op($sformatf("rand%0d", i), ra, rb, rc, exp9[7:0], exp9[8]);
        end

        // WIDTH=1: exhaustive, done one edge after the accepting edge
        for (int r = 0; r < 3; r++) begin
            for (int v = 0; v < 8; v++) begin
                logic [2:0] bits;
                logic [1:0] exp2;
                bits = 3'(v);
                exp2 = {1'b0, bits[2]} + {1'b0, bits[1]} + {1'b0, bits[0]};
                @(negedge clk);
                start1 = 1'b1; a1 = bits[2]; b1 = bits[1]; cin1 = bits[0];
                @(posedge clk);
                #1;
                start1 = 1'b0; a1 = ~bits[2]; b1 = ~bits[1]; cin1 = ~bits[0];
                check($sformatf("w1_busy_%0d", v), {busy1, done1}, 2'b10);
                @(posedge clk);
                #1;
                check($sformatf("w1_done_%0d", v), {busy1, done1}, 2'b01);
                check($sformatf("w1_sum_%0d", v), {cout1, sum1}, exp2);
                @(posedge clk);
                #1;
                check($sformatf("w1_pulse_%0d", v), {busy1, done1}, 2'b00);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
